uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter among NUM_REQ byte-stream requesters, e.g. the RX echo path, debug status, and trace dump.
- Arbitration is round-robin at packet granularity. The grant holds until the owner's last byte, or until MAX_BURST bytes have been sent.
- Sequences the transmitter through tx_start/tx_busy and inserts an optional idle gap between bytes.
- Sits between the requester logic and the transmitter inside main, on iCE_CLK.

---
 rtl/uart_arb_pkg.sv | 25 ++
 rtl/uart_tx_arbiter_rr_picker.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the controller state encoding, default parameters and a width helper.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OWN,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } arb_state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_MAX_BURST  = 16;
  localparam int DEF_GAP_CYCLES = 0;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin one-hot picker: first set request searching upward from pointer+1 with wrap.
// Purely combinational, no backpressure.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   index
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    onehot = '0;
    index  = '0;
    found  = 1'b0;
    cand   = '0;
    // k = NUM_REQ revisits the pointer itself last, so the previous owner has lowest priority
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(pointer) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found         = 1'b1;
        onehot[cand]  = 1'b1;
        index         = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte streams, round-robin per packet or MAX_BURST bytes.
// Grant 1 cycle after request, tx_start 1 cycle after accept; requesters stall while the transmitter is busy.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                      iCE_CLK,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_byte,
  input  logic                      tx_busy,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      grant_valid,
  output logic                      burst_trunc
);

  localparam int IDX_W = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);
  localparam int CNT_W = (clog2(MAX_BURST + 1) < 1) ? 1 : clog2(MAX_BURST + 1);
  localparam int GAP_W = (clog2(GAP_CYCLES + 1) < 1) ? 1 : clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(NUM_REQ - 1);

  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                last_q, last_d;
  logic                start_q, start_d;
  logic                trunc_q, trunc_d;
  logic [DATA_W-1:0]   byte_q, byte_d;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]    pick_idx;
  logic                owner_vld, owner_last, do_release;
  logic [DATA_W-1:0]   owner_dat;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (req_valid),
    .pointer (ptr_q),
    .onehot  (pick_onehot),
    .index   (pick_idx)
  );

  always_comb begin
    owner_vld  = 1'b0;
    owner_last = 1'b0;
    owner_dat  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_vld  = req_valid[i];
        owner_last = req_last[i];
        owner_dat  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    last_d     = last_q;
    byte_d     = byte_q;
    start_d    = 1'b0;
    trunc_d    = 1'b0;
    do_release = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = OWN;
          grant_d = pick_onehot;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      OWN: begin
        if (owner_vld) begin
          byte_d  = owner_dat;
          start_d = 1'b1;
          last_d  = owner_last;
          cnt_d   = cnt_q + 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = '0;
          end else begin
            do_release = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) do_release = 1'b1;
        else                   gap_d = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // A packet end takes precedence, so last on the final allowed byte is not a truncation
    if (do_release) begin
      if (last_q || (cnt_q == BURST_MAX)) begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = owner_q;
        trunc_d = !last_q;
      end else begin
        state_d = OWN;
      end
    end
  end

  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
      gap_q   <= '0;
      last_q  <= 1'b0;
      start_q <= 1'b0;
      trunc_q <= 1'b0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
      start_q <= start_d;
      trunc_q <= trunc_d;
      byte_q  <= byte_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign req_ready   = (state_q == OWN) ? grant_q : '0;
  assign tx_start    = start_q;
  assign tx_byte     = byte_q;
  assign burst_trunc = trunc_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: dut_a (MAX_BURST=4, no gap) and dut_b (GAP_CYCLES=3) share clock and reset.
// Requester FIFOs feed bytes; a scoreboard checks every tx_start against the expected byte/grant order.
module tb_uart_tx_arbiter;

  localparam int NR     = 4;
  localparam int DW     = 8;
  localparam int TX_LEN = 4;
  localparam int NSCEN  = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid_a, req_last_a, req_ready_a, grant_a;
  logic [NR*DW-1:0] req_data_a;
  logic             tx_start_a, tx_busy_a, grant_valid_a, burst_trunc_a;
  logic [DW-1:0]    tx_byte_a;
  logic [NR-1:0]    req_valid_b, req_last_b, req_ready_b, grant_b;
  logic [NR*DW-1:0] req_data_b;
  logic             tx_start_b, tx_busy_b, grant_valid_b, burst_trunc_b;
  logic [DW-1:0]    tx_byte_b;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(4), .GAP_CYCLES(0)) dut_a (
    .iCE_CLK(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_data(req_data_a),
    .req_last(req_last_a), .req_ready(req_ready_a), .tx_start(tx_start_a), .tx_byte(tx_byte_a),
    .tx_busy(tx_busy_a), .grant(grant_a), .grant_valid(grant_valid_a), .burst_trunc(burst_trunc_a)
  );

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(16), .GAP_CYCLES(3)) dut_b (
    .iCE_CLK(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_data(req_data_b),
    .req_last(req_last_b), .req_ready(req_ready_b), .tx_start(tx_start_b), .tx_byte(tx_byte_b),
    .tx_busy(tx_busy_b), .grant(grant_b), .grant_valid(grant_valid_b), .burst_trunc(burst_trunc_b)
  );

  // Transmitter models: busy for TX_LEN cycles starting the cycle after tx_start, unaffected by rst_n
  int busy_cnt_a = 0;
  int busy_cnt_b = 0;
  always @(posedge clk) begin
    if (tx_start_a)          busy_cnt_a <= TX_LEN;
    else if (busy_cnt_a > 0) busy_cnt_a <= busy_cnt_a - 1;
    if (tx_start_b)          busy_cnt_b <= TX_LEN;
    else if (busy_cnt_b > 0) busy_cnt_b <= busy_cnt_b - 1;
  end
  assign tx_busy_a = (busy_cnt_a != 0);
  assign tx_busy_b = (busy_cnt_b != 0);

  typedef struct packed {
    logic [3:0] g;
    logic [7:0] b;
  } exp_t;

  typedef struct {
    int         scen;
    int         dut;
    int         rq;
    logic [7:0] dat;
    logic       last;
    logic [3:0] eg;
  } vec_t;

  vec_t vecs[$];
  exp_t qa[$];
  exp_t qb[$];
  int   exp_trunc[NSCEN] = '{0, 0, 0, 1, 0, 0};
  int   gaps[2] = '{0, 3};

  logic [8:0] stim[8][64];
  int         hd[8];
  int         tl[8];

  int checks = 0;
  int errors = 0;
  int trunc_seen = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_tx(input int d, input logic [7:0] byt, input logic [3:0] g);
    exp_t e;
    if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL tx_unexpected dut%0d: got byte 0x%0h, required no tx_start", d, byt);
    end else begin
      if (d == 0) e = qa.pop_front();
      else        e = qb.pop_front();
      chk($sformatf("tx_byte dut%0d", d), 32'(byt), 32'(e.b));
      chk($sformatf("tx_grant dut%0d", d), 32'(g), 32'(e.g));
    end
  endtask

  task automatic add(input int sc, input int d, input int rq, input logic [7:0] dat,
                     input logic last, input logic [3:0] eg);
    vec_t v;
    v.scen = sc; v.dut = d; v.rq = rq; v.dat = dat; v.last = last; v.eg = eg;
    vecs.push_back(v);
  endtask

  task automatic clear_streams();
    for (int s = 0; s < 8; s++) begin
      hd[s] = 0;
      tl[s] = 0;
    end
  endtask

  task automatic push_byte(input int d, input int rq, input logic [7:0] dat,
                           input logic last, input logic [3:0] eg);
    int   idx;
    exp_t e;
    idx = d * 4 + rq;
    stim[idx][tl[idx]] = {last, dat};
    tl[idx]++;
    e.g = eg;
    e.b = dat;
    if (d == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || grant_valid_a || grant_valid_b ||
            tx_busy_a || tx_busy_b) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s timeout: pending a=%0d b=%0d after %0d cycles, required drained",
               nm, qa.size(), qb.size(), n);
    end
  endtask

  function automatic int remaining();
    int r;
    r = 0;
    for (int s = 0; s < 8; s++) r += tl[s] - hd[s];
    return r;
  endfunction

  // Requester driver: pops a byte after the edge on which valid&ready was seen
  initial begin
    logic       acc[8];
    logic [7:0] vall, lall;
    logic [63:0] dall;
    logic [8:0] w;
    req_valid_a = '0; req_last_a = '0; req_data_a = '0;
    req_valid_b = '0; req_last_b = '0; req_data_b = '0;
    forever begin
      @(negedge clk);
      for (int s = 0; s < 8; s++)
        acc[s] = (s < 4) ? (req_valid_a[s] && req_ready_a[s]) : (req_valid_b[s-4] && req_ready_b[s-4]);
      @(posedge clk);
      #1;
      vall = '0; lall = '0; dall = '0;
      for (int s = 0; s < 8; s++) begin
        if (acc[s] && hd[s] < tl[s]) hd[s]++;
        if (hd[s] < tl[s]) begin
          w = stim[s][hd[s]];
          vall[s] = 1'b1;
          lall[s] = w[8];
          dall[s*8 +: 8] = w[7:0];
        end
      end
      req_valid_a = vall[3:0]; req_last_a = lall[3:0]; req_data_a = dall[31:0];
      req_valid_b = vall[7:4]; req_last_b = lall[7:4]; req_data_b = dall[63:32];
    end
  end

  // Monitor: scoreboard pops plus timing relative to the last tx_busy fall
  int   last_fall[2];
  logic prev_busy[2], prev_gv[2], prev_rdy[2];
  logic prev_rst = 1'b0;
  always @(negedge clk) begin
    logic       bz[2], gv[2];
    logic [3:0] rd[2], gr[2];
    cyc++;
    bz[0] = tx_busy_a;     bz[1] = tx_busy_b;
    gv[0] = grant_valid_a; gv[1] = grant_valid_b;
    rd[0] = req_ready_a;   rd[1] = req_ready_b;
    gr[0] = grant_a;       gr[1] = grant_b;
    if (rst_n && prev_rst) begin
      if (tx_start_a) check_tx(0, tx_byte_a, grant_a);
      if (tx_start_b) check_tx(1, tx_byte_b, grant_b);
      if (burst_trunc_a) begin
        trunc_seen++;
        chk("trunc_with_release", 32'(grant_valid_a), 32'd0);
      end
      if (burst_trunc_b) trunc_seen++;
      for (int d = 0; d < 2; d++) begin
        if (prev_busy[d] && !bz[d]) last_fall[d] = cyc;
        if (prev_gv[d] && !gv[d])
          chk($sformatf("grant_drop_delay dut%0d", d), 32'(cyc - last_fall[d]), 32'(gaps[d] + 1));
        if (!prev_rdy[d] && rd[d] != 0 && prev_gv[d])
          chk($sformatf("ready_return_delay dut%0d", d), 32'(cyc - last_fall[d]), 32'(gaps[d] + 1));
        if (rd[d] != 0) chk($sformatf("ready_is_grant dut%0d", d), 32'(rd[d]), 32'(gr[d]));
      end
    end
    for (int d = 0; d < 2; d++) begin
      prev_busy[d] = bz[d];
      prev_gv[d]   = gv[d];
      prev_rdy[d]  = (rd[d] != 0);
    end
    prev_rst = rst_n;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    clear_streams();
    // Rows listed in expected transmit order: inputs {dut, requester, byte, last}, expected grant
    add(0, 0, 0, 8'hA5, 1'b1, 4'b0001);
    add(1, 0, 0, 8'h10, 1'b1, 4'b0001);
    add(1, 0, 1, 8'h11, 1'b1, 4'b0010);
    add(1, 0, 2, 8'h12, 1'b1, 4'b0100);
    add(1, 0, 3, 8'h13, 1'b1, 4'b1000);
    add(1, 0, 0, 8'h14, 1'b1, 4'b0001);
    add(2, 0, 1, 8'h20, 1'b0, 4'b0010);
    add(2, 0, 1, 8'h21, 1'b0, 4'b0010);
    add(2, 0, 1, 8'h22, 1'b1, 4'b0010);
    add(2, 0, 2, 8'h2A, 1'b1, 4'b0100);
    for (int i = 0; i < 4; i++) add(3, 0, 0, 8'(8'h30 + i), 1'b0, 4'b0001);
    add(3, 0, 3, 8'h3F, 1'b1, 4'b1000);
    add(3, 0, 0, 8'h34, 1'b0, 4'b0001);
    add(3, 0, 0, 8'h35, 1'b0, 4'b0001);
    add(3, 0, 0, 8'h36, 1'b1, 4'b0001);
    add(4, 0, 1, 8'h50, 1'b0, 4'b0010);
    add(4, 0, 1, 8'h51, 1'b0, 4'b0010);
    add(4, 0, 1, 8'h52, 1'b0, 4'b0010);
    add(4, 0, 1, 8'h53, 1'b1, 4'b0010);
    add(5, 1, 2, 8'h40, 1'b0, 4'b0100);
    add(5, 1, 2, 8'h41, 1'b1, 4'b0100);

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs dut_a", 32'({grant_a, grant_valid_a, req_ready_a, tx_start_a, tx_byte_a, burst_trunc_a}), 32'd0);
    chk("reset_outputs dut_b", 32'({grant_b, grant_valid_b, req_ready_b, tx_start_b, tx_byte_b, burst_trunc_b}), 32'd0);

    for (int sc = 0; sc < NSCEN; sc++) begin
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      clear_streams();
      foreach (vecs[i])
        if (vecs[i].scen == sc) push_byte(vecs[i].dut, vecs[i].rq, vecs[i].dat, vecs[i].last, vecs[i].eg);
      trunc_seen = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      wait_idle($sformatf("scenario%0d", sc));
      chk($sformatf("burst_trunc_pulses scenario%0d", sc), 32'(trunc_seen), 32'(exp_trunc[sc]));
      chk($sformatf("bytes_left scenario%0d", sc), 32'(remaining()), 32'd0);
    end

    // Reset while the controller waits in WAIT_DONE with the transmitter still busy
    begin
      int n;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      clear_streams();
      push_byte(0, 1, 8'h55, 1'b1, 4'b0010);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (!tx_busy_a && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("reset_test_busy_seen", 32'(n < 100), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midop_reset_outputs", 32'({grant_a, grant_valid_a, req_ready_a, tx_start_a, tx_byte_a, burst_trunc_a}), 32'd0);
      chk("midop_reset_queue", 32'(qa.size()), 32'd0);
      clear_streams();
      push_byte(0, 0, 8'h60, 1'b1, 4'b0001);
      push_byte(0, 1, 8'h61, 1'b1, 4'b0010);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      wait_idle("post_reset_order");
      chk("post_reset_bytes_left", 32'(remaining()), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
